// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, default round count
// and the initial hash value used by the hash-state register and var-init mux.
package sha256_pkg;

  localparam int NUM_ROUNDS_DEF = 64;

  typedef logic [2:0] ctrl_state_t;

  localparam ctrl_state_t ST_IDLE  = 3'd0;
  localparam ctrl_state_t ST_LOAD  = 3'd1;
  localparam ctrl_state_t ST_ROUND = 3'd2;
  localparam ctrl_state_t ST_FINAL = 3'd3;
  localparam ctrl_state_t ST_HOLD  = 3'd4;

  localparam logic [31:0] IV_H0 = 32'h6a09e667;
  localparam logic [31:0] IV_H1 = 32'hbb67ae85;
  localparam logic [31:0] IV_H2 = 32'h3c6ef372;
  localparam logic [31:0] IV_H3 = 32'ha54ff53a;
  localparam logic [31:0] IV_H4 = 32'h510e527f;
  localparam logic [31:0] IV_H5 = 32'h9b05688c;
  localparam logic [31:0] IV_H6 = 32'h1f83d9ab;
  localparam logic [31:0] IV_H7 = 32'h5be0cd19;

  // H0 sits in the most significant word, matching the a..h packing order.
  localparam logic [255:0] IV_STATE = {IV_H0, IV_H1, IV_H2, IV_H3,
                                       IV_H4, IV_H5, IV_H6, IV_H7};

  function automatic logic [31:0] iv_word(input logic [2:0] idx);
    logic [31:0] w;
    w = '0;
    case (idx)
      3'd0: w = IV_H0;
      3'd1: w = IV_H1;
      3'd2: w = IV_H2;
      3'd3: w = IV_H3;
      3'd4: w = IV_H4;
      3'd5: w = IV_H5;
      3'd6: w = IV_H6;
      default: w = IV_H7;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha256_round_cnt.sv
// Round index counter: clears to zero, counts while enabled and flags the last
// round so the controller can leave the ROUND state without a visible wrap.
module sha256_round_cnt
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int ROUND_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  output logic [ROUND_W-1:0] cnt,
  output logic               tc
);

  localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NUM_ROUNDS - 1);

  assign tc = (cnt == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tc) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ROUND_W'(1);
      end
    end
  end

endmodule

// File: rtl/sha256_block_ctrl.sv
// SHA-256 block sequencer: accepts message blocks, steps the round core through
// one compression and tracks message boundaries for IV re-init and digest hand-off.
module sha256_block_ctrl
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int ROUND_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               blk_valid,
  input  logic               blk_last,
  output logic               blk_ready,
  output logic               load_w,
  output logic               init_vars,
  output logic               iv_sel,
  output logic               hash_init,
  output logic               round_en,
  output logic [ROUND_W-1:0] round_idx,
  output logic               hash_update,
  output logic               digest_valid,
  input  logic               digest_ack,
  output logic               busy
);

  ctrl_state_t state;
  logic        first;
  logic        last_q;
  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_tc;

  assign cnt_clr = (state == ST_LOAD);
  assign cnt_en  = (state == ST_ROUND);

  sha256_round_cnt #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .ROUND_W    (ROUND_W)
  ) u_round_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (round_idx),
    .tc    (cnt_tc)
  );

  // first marks the next accepted block as the start of a message; it is
  // refreshed in FINAL so an abandoned block (reset) leaves it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      first  <= 1'b1;
      last_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (blk_valid) begin
            last_q <= blk_last;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= ST_ROUND;
        end
        ST_ROUND: begin
          if (cnt_tc) begin
            state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          first <= last_q;
          state <= last_q ? ST_HOLD : ST_IDLE;
        end
        ST_HOLD: begin
          if (digest_ack) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // load_w is the accept strobe itself, so the W schedule latches the block
  // on the same edge the handshake completes.
  always_comb begin
    blk_ready    = 1'b0;
    load_w       = 1'b0;
    init_vars    = 1'b0;
    iv_sel       = 1'b0;
    hash_init    = 1'b0;
    round_en     = 1'b0;
    hash_update  = 1'b0;
    digest_valid = 1'b0;
    busy         = 1'b0;
    case (state)
      ST_IDLE: begin
        blk_ready = 1'b1;
        load_w    = blk_valid;
      end
      ST_LOAD: begin
        init_vars = 1'b1;
        iv_sel    = first;
        hash_init = first;
        busy      = 1'b1;
      end
      ST_ROUND: begin
        round_en = 1'b1;
        busy     = 1'b1;
      end
      ST_FINAL: begin
        hash_update = 1'b1;
        busy        = 1'b1;
      end
      ST_HOLD: begin
        digest_valid = 1'b1;
      end
      default: begin
        blk_ready = 1'b0;
      end
    endcase
  end

endmodule
